// File: rtl/key_input_conditioner_if.sv
// Bundles the key inputs and conditioned key outputs of key_input_conditioner.
// The game logic or bench drives the master side; the conditioner sits on the slave side.
interface key_input_conditioner_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key;
  logic [N_KEYS-1:0] repeat_en;
  logic [N_KEYS-1:0] keyLevel;
  logic [N_KEYS-1:0] pressedKey;
  logic [N_KEYS-1:0] releasedKey;
  logic              anyPressed;

  modport master (
    output key,
    output repeat_en,
    input  keyLevel,
    input  pressedKey,
    input  releasedKey,
    input  anyPressed
  );

  modport slave (
    input  key,
    input  repeat_en,
    output keyLevel,
    output pressedKey,
    output releasedKey,
    output anyPressed
  );
endinterface

// File: rtl/key_input_conditioner.sv
// Multi-channel push-button conditioner: per key a 2-flop synchroniser, a debouncer,
// registered press/release pulses and an optional hold-to-repeat FSM.
module key_input_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input logic                   Clock,
  input logic                   Reset,
  key_input_conditioner_if.slave bus
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HOLD   = 2'b01,
    ST_REPEAT = 2'b10
  } state_t;

  logic [N_KEYS-1:0] level_s;
  logic [N_KEYS-1:0] press_s;
  logic [N_KEYS-1:0] release_s;

  for (genvar ch = 0; ch < N_KEYS; ch++) begin : g_ch
    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [DW-1:0] dcnt_r;
    logic [DW-1:0] dcnt_s;
    logic          flip_s;
    logic [RW-1:0] rcnt_r;
    logic [RW-1:0] rcnt_s;
    state_t        state_r;
    state_t        state_s;
    logic          rep_fire_s;
    logic          press_r;
    logic          release_r;

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
      flip_s = 1'b0;
      dcnt_s = dcnt_r;
      if (sync2_r == level_r) begin
        dcnt_s = '0;
      end else if (dcnt_r == DEB_LAST) begin
        flip_s = 1'b1;
        dcnt_s = '0;
      end else begin
        dcnt_s = dcnt_r + DW'(1);
      end
    end

    // Repeat FSM next state; a debounced edge overrides any repeat decision this cycle
    always_comb begin
      state_s    = state_r;
      rcnt_s     = rcnt_r;
      rep_fire_s = 1'b0;
      if (flip_s && sync2_r) begin
        state_s = ST_HOLD;
        rcnt_s  = '0;
      end else if (flip_s) begin
        state_s = ST_IDLE;
        rcnt_s  = '0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            rcnt_s = '0;
          end
          ST_HOLD: begin
            if (!bus.repeat_en[ch]) begin
              rcnt_s = '0;
            end else if (rcnt_r == DELAY_LAST) begin
              rep_fire_s = 1'b1;
              rcnt_s     = '0;
              state_s    = ST_REPEAT;
            end else begin
              rcnt_s = rcnt_r + RW'(1);
            end
          end
          ST_REPEAT: begin
            // Dropping the enable falls back to HOLD so re-enabling waits the full delay
            if (!bus.repeat_en[ch]) begin
              rcnt_s  = '0;
              state_s = ST_HOLD;
            end else if (rcnt_r == PERIOD_LAST) begin
              rep_fire_s = 1'b1;
              rcnt_s     = '0;
            end else begin
              rcnt_s = rcnt_r + RW'(1);
            end
          end
          default: begin
            state_s = ST_IDLE;
            rcnt_s  = '0;
          end
        endcase
      end
    end

    // Channel state registers and registered pulses
    always_ff @(posedge Clock) begin
      if (!Reset) begin
        sync1_r   <= 1'b0;
        sync2_r   <= 1'b0;
        level_r   <= 1'b0;
        dcnt_r    <= '0;
        rcnt_r    <= '0;
        state_r   <= ST_IDLE;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        sync1_r   <= bus.key[ch];
        sync2_r   <= sync1_r;
        dcnt_r    <= dcnt_s;
        rcnt_r    <= rcnt_s;
        state_r   <= state_s;
        level_r   <= flip_s ? sync2_r : level_r;
        press_r   <= (flip_s & sync2_r) | rep_fire_s;
        release_r <= flip_s & ~sync2_r;
      end
    end

    assign level_s[ch]   = level_r;
    assign press_s[ch]   = press_r;
    assign release_s[ch] = release_r;
  end

  assign bus.keyLevel    = level_s;
  assign bus.pressedKey  = press_s;
  assign bus.releasedKey = release_s;
  assign bus.anyPressed  = |level_s;

endmodule
